ram_readout_arbiter: RTL

//  Shares the single IPbus DPRAM write port between N_CH TDC data channels.

---
 rtl/ram_readout_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ram_readout_arbiter.sv
// Purpose : round-robin arbiter copying one channel frame at a time into the IPbus DPRAM, then handshaking with the PC.
// Latency : ch_grant 1 cycle after ch_req; each valid word written 1 cycle later; handshakeFPGA 1 cycle after the last write.
// Backpr. : channels are throttled by ch_grant alone; ch_valid gaps stall the frame until the idle timeout aborts it.
// Config  : `define ARB_HEADER_EN adds a header word at address 0 after the data (data then starts at address 1).
// Ports   : SYSCLK/RESET (async, active high); ch_req/ch_data/ch_valid in, ch_grant/ch_done out per channel;
//           IPbus_RAM_data/_address/_we registered DPRAM write port; handshakePC in (async), handshakeFPGA out;
//           frame_cnt counts handed-off frames (wraps).
module ram_readout_arbiter #(
  parameter int N_CH      = 4,
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT_W = 12
) (
  input  logic                   SYSCLK,
  input  logic                   RESET,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  output logic [N_CH-1:0]        ch_grant,
  output logic [N_CH-1:0]        ch_done,
  output logic [DATA_W-1:0]      IPbus_RAM_data,
  output logic [ADDR_W-1:0]      IPbus_RAM_address,
  output logic                   IPbus_RAM_we,
  input  logic                   handshakePC,
  output logic                   handshakeFPGA,
  output logic [15:0]            frame_cnt
);

  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WIDX_W = 8;
`ifdef ARB_HEADER_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif
  // Stall exit happens on the idle cycle that would bring the counter to all-ones.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
  localparam logic [WIDX_W-1:0]    W_LAST  = WIDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_XFER, S_HDR, S_WAIT_ACK, S_WAIT_REL} state_t;

`ifdef ARB_HEADER_EN
  localparam state_t S_POST = S_HDR;
`else
  localparam state_t S_POST = S_WAIT_ACK;
`endif

  state_t               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_gidx;
  logic [WIDX_W-1:0]    r_widx;
  logic [TIMEOUT_W-1:0] r_timeout;
  logic                 r_pc_meta;
  logic                 r_pc_sync;
  logic [N_CH-1:0]      r_grant;
  logic [N_CH-1:0]      r_done;
  logic [DATA_W-1:0]    r_data;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_we;
  logic                 r_hs;
  logic [15:0]          r_frame_cnt;

`ifdef ARB_HEADER_EN
  logic        r_err;
  logic [31:0] w_hdr;
  // frame_cnt here is still the pre-increment value of the frame being handed off.
  assign w_hdr = {8'hA5, 4'(r_gidx), 3'b000, r_err, r_frame_cnt};
`endif

  // Round robin: scan downward so the nearest requester after rr_ptr is the last to assign.
  logic [IDX_W-1:0] w_next;
  logic             w_any;
  always_comb begin
    w_next = r_rr_ptr;
    w_any  = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      if (ch_req[IDX_W'((int'(r_rr_ptr) + k) % N_CH)]) begin
        w_next = IDX_W'((int'(r_rr_ptr) + k) % N_CH);
        w_any  = 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] w_gdata;
  logic              w_gvalid;
  logic              w_last;
  logic              w_stall_out;
  assign w_gdata     = ch_data[int'(r_gidx)*DATA_W +: DATA_W];
  assign w_gvalid    = ch_valid[r_gidx];
  assign w_last      = w_gvalid && (r_widx == W_LAST);
  assign w_stall_out = !w_gvalid && (r_timeout == TO_LAST);

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IDX_W'(N_CH - 1);
      r_gidx      <= '0;
      r_widx      <= '0;
      r_timeout   <= '0;
      r_pc_meta   <= 1'b0;
      r_pc_sync   <= 1'b0;
      r_grant     <= '0;
      r_done      <= '0;
      r_data      <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_hs        <= 1'b0;
      r_frame_cnt <= '0;
`ifdef ARB_HEADER_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_pc_meta <= handshakePC;
      r_pc_sync <= r_pc_meta;
      r_we      <= 1'b0;
      r_done    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gidx    <= w_next;
            r_rr_ptr  <= w_next;
            r_grant   <= N_CH'(1) << w_next;
            r_widx    <= '0;
            r_timeout <= '0;
            r_state   <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_gvalid) begin
            r_we      <= 1'b1;
            r_data    <= w_gdata;
            r_addr    <= ADDR_W'(r_widx) + ADDR_W'(BASE);
            r_widx    <= r_widx + 1'b1;
            r_timeout <= '0;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
`ifdef ARB_HEADER_EN
          if (w_stall_out) r_err <= 1'b1;
`endif
          if (w_last || w_stall_out) begin
            r_grant <= '0;
            r_state <= S_POST;
          end
        end
`ifdef ARB_HEADER_EN
        S_HDR: begin
          r_we    <= 1'b1;
          r_addr  <= '0;
          r_data  <= DATA_W'(w_hdr);
          r_state <= S_WAIT_ACK;
        end
`endif
        S_WAIT_ACK: begin
          // First cycle raises the flag; an already-high acknowledge is accepted without an edge.
          if (!r_hs) begin
            r_hs <= 1'b1;
          end else if (r_pc_sync) begin
            r_hs    <= 1'b0;
            r_state <= S_WAIT_REL;
          end
        end
        S_WAIT_REL: begin
          if (!r_pc_sync) begin
            r_done      <= N_CH'(1) << r_gidx;
            r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef ARB_HEADER_EN
            r_err       <= 1'b0;
`endif
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_grant          = r_grant;
  assign ch_done           = r_done;
  assign IPbus_RAM_data    = r_data;
  assign IPbus_RAM_address = r_addr;
  assign IPbus_RAM_we      = r_we;
  assign handshakeFPGA     = r_hs;
  assign frame_cnt         = r_frame_cnt;

endmodule
